// File: rtl/kbd_spi_rx_if.sv
// Pin bundle between the PS2 MCU link / CPU address bus and the keyboard receiver.
interface kbd_spi_rx_if;
  logic       KBD_CLK;
  logic       KBD_CS;
  logic       KBD_DI;
  logic [7:0] A_HI;
  logic [4:0] KBD_COLS;
  logic [4:0] JOY;
  logic       FRAME_STB;
  logic       FRAME_ERR;

  modport slave (
    input  KBD_CLK, KBD_CS, KBD_DI, A_HI,
    output KBD_COLS, JOY, FRAME_STB, FRAME_ERR
  );

  modport master (
    output KBD_CLK, KBD_CS, KBD_DI, A_HI,
    input  KBD_COLS, JOY, FRAME_STB, FRAME_ERR
  );
endinterface

// File: rtl/kbd_spi_rx.sv
// SPI mode-0 slave holding the Spectrum key matrix and Kempston state sent by the PS2 MCU;
// answers port #FE row scans combinationally from A[15:8].
module kbd_spi_rx #(
  parameter int SYNC_STAGES = 2
) (
  input logic         clk14m,
  input logic         CPU_RESET,
  kbd_spi_rx_if.slave bus
);

  localparam logic [6:0] FRAME_BITS = 7'd72;
  localparam logic [6:0] CNT_MAX    = 7'd127;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] di_sync;
  logic                   clk_d;
  logic                   cs_d;

  logic clk_s, cs_s, di_s;
  logic clk_rise, cs_fall, cs_rise, shift_en;

  logic [71:0] sr;
  logic [6:0]  cnt;
  logic [4:0]  row [0:7];
  logic [4:0]  joy;
  logic        stb;
  logic        err;
  logic [4:0]  cols;
  logic        unused_sr_msb;

  // Synchronizers come out of reset as "link idle": clock low, CS high, data high.
  always_ff @(posedge clk14m or negedge CPU_RESET) begin
    if (!CPU_RESET) begin
      clk_sync <= '0;
      cs_sync  <= '1;
      di_sync  <= '1;
      clk_d    <= 1'b0;
      cs_d     <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], bus.KBD_CLK};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], bus.KBD_CS};
      di_sync  <= {di_sync[SYNC_STAGES-2:0], bus.KBD_DI};
      clk_d    <= clk_sync[SYNC_STAGES-1];
      cs_d     <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign di_s     = di_sync[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_d;
  assign cs_fall  = ~cs_s & cs_d;
  assign cs_rise  = cs_s & ~cs_d;
  assign shift_en = clk_rise & ~cs_s;

  always_ff @(posedge clk14m or negedge CPU_RESET) begin
    if (!CPU_RESET) begin
      sr  <= '1;
      cnt <= '0;
      joy <= '0;
      stb <= 1'b0;
      err <= 1'b0;
      for (int r = 0; r < 8; r++) row[r] <= 5'b11111;
    end else begin
      stb <= 1'b0;
      err <= 1'b0;
      if (shift_en) sr <= {sr[70:0], di_s};
      // A clock edge landing together with the CS fall is the first bit of the new frame.
      if (cs_fall)
        cnt <= clk_rise ? 7'd1 : 7'd0;
      else if (shift_en && cnt != CNT_MAX)
        cnt <= cnt + 7'd1;
      if (cs_rise) begin
        if (cnt == FRAME_BITS) begin
          for (int r = 0; r < 8; r++) row[r] <= sr[68-8*r -: 5];
          joy <= sr[4:0];
          stb <= 1'b1;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    cols = 5'b11111;
    for (int r = 0; r < 8; r++)
      if (!bus.A_HI[r]) cols = cols & row[r];
  end

  assign unused_sr_msb = sr[71];

  assign bus.KBD_COLS  = cols;
  assign bus.JOY       = joy;
  assign bus.FRAME_STB = stb;
  assign bus.FRAME_ERR = err;

endmodule

// File: tb/tb_kbd_spi_rx.sv
// Directed bench for kbd_spi_rx: strobes/JOY checked by a queue-driven monitor, row scans checked inline.
module tb_kbd_spi_rx;

  logic clk14m    = 1'b0;
  logic CPU_RESET = 1'b0;

  kbd_spi_rx_if bus ();

  kbd_spi_rx #(.SYNC_STAGES(2)) dut (
    .clk14m   (clk14m),
    .CPU_RESET(CPU_RESET),
    .bus      (bus)
  );

  always #35 clk14m = ~clk14m;

  typedef struct {
    logic       err;
    logic [4:0] joy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest expected frame outcome.
  exp_t e;
  always @(negedge clk14m) begin
    if (CPU_RESET && (bus.FRAME_STB === 1'b1 || bus.FRAME_ERR === 1'b1)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got stb=%b err=%b expected none",
                 bus.FRAME_STB, bus.FRAME_ERR);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_kind", {3'b000, bus.FRAME_STB, bus.FRAME_ERR}, {3'b000, ~e.err, e.err});
        chk("joy_at_strobe", bus.JOY, e.joy);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk14m);
  endtask

  task automatic shift_bits(input logic [79:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus.KBD_DI = d[i];
      cycles(2);
      bus.KBD_CLK = 1'b1;
      cycles(5);
      bus.KBD_CLK = 1'b0;
      cycles(3);
    end
  endtask

  task automatic send(input logic [79:0] d, input int n, input logic is_err, input logic [4:0] joy_exp);
    bus.KBD_CS = 1'b0;
    cycles(5);
    shift_bits(d, n);
    cycles(3);
    exp_q.push_back('{err: is_err, joy: joy_exp});
    bus.KBD_CS = 1'b1;
    cycles(8);
  endtask

  task automatic cols(input logic [7:0] a, input logic [4:0] exp, input string name);
    bus.A_HI = a;
    #1;
    chk(name, bus.KBD_COLS, exp);
  endtask

  logic [7:0] idle_addr [5] = '{8'h00, 8'hFE, 8'h7F, 8'hFF, 8'hAA};

  initial begin
    bus.KBD_CLK = 1'b0;
    bus.KBD_CS  = 1'b1;
    bus.KBD_DI  = 1'b1;
    bus.A_HI    = 8'hFF;
    cycles(4);
    CPU_RESET = 1'b1;
    cycles(6);

    foreach (idle_addr[i]) cols(idle_addr[i], 5'b11111, "idle_cols");
    chk("idle_joy", bus.JOY, 5'b00000);

    // CAPS SHIFT held, fire pressed
    send({8'hFE, {7{8'hFF}}, 8'h10}, 72, 1'b0, 5'b10000);
    cols(8'hFE, 5'b11110, "f1_row0");
    cols(8'hFD, 5'b11111, "f1_row1");
    chk("f1_joy", bus.JOY, 5'b10000);

    send({8'hFE, {6{8'hFF}}, 8'hFD, 8'h03}, 72, 1'b0, 5'b00011);
    cols(8'h7E, 5'b11100, "f2_row0_row7");
    cols(8'hFF, 5'b11111, "f2_none");
    cols(8'h7F, 5'b11101, "f2_row7");
    chk("f2_joy", bus.JOY, 5'b00011);

    // Short and long frames of all-pressed data must be rejected
    send(80'h0, 71, 1'b1, 5'b00011);
    send(80'h0, 73, 1'b1, 5'b00011);
    cols(8'h7E, 5'b11100, "err_keep_rows");
    cols(8'h00, 5'b11100, "err_keep_all");
    chk("err_keep_joy", bus.JOY, 5'b00011);

    // Stray clocks with CS high
    for (int i = 0; i < 10; i++) begin
      bus.KBD_DI = i[0];
      cycles(2);
      bus.KBD_CLK = 1'b1;
      cycles(5);
      bus.KBD_CLK = 1'b0;
      cycles(3);
    end
    send({{3{8'hFF}}, 8'hEF, {4{8'hFF}}, 8'hFF}, 72, 1'b0, 5'b11111);
    cols(8'hF7, 5'b01111, "f4_row3");
    cols(8'hFE, 5'b11111, "f4_row0");
    chk("f4_joy", bus.JOY, 5'b11111);

    // Reset mid-frame
    bus.KBD_CS = 1'b0;
    cycles(5);
    shift_bits(80'h0, 40);
    CPU_RESET = 1'b0;
    cycles(2);
    cols(8'h00, 5'b11111, "rst_cols");
    chk("rst_joy", bus.JOY, 5'b00000);
    bus.KBD_CS  = 1'b1;
    bus.KBD_CLK = 1'b0;
    cycles(3);
    CPU_RESET = 1'b1;
    cycles(6);
    cols(8'h00, 5'b11111, "post_rst_cols");
    send({{5{8'hFF}}, 8'hFB, {2{8'hFF}}, 8'h01}, 72, 1'b0, 5'b00001);
    cols(8'hDF, 5'b11011, "f5_row5");
    cols(8'h00, 5'b11011, "f5_all");
    chk("f5_joy", bus.JOY, 5'b00001);

    cycles(10);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_strobes: got %0d outstanding expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
